// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - VGA-style scanout of a 1-bit double-buffered framebuffer
//
// Generates horizontal/vertical timing, fetches one pixel per ce step from the
// front buffer and drives the video pins through a two-stage pipeline. At the
// start of the first vertical blanking line it exchanges front/back buffers when
// the renderer reports a finished frame, and pulses swap for one clk.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ce            pixel-rate enable; all state advances only when ce=1
//   frame_done    level: back buffer complete and may be shown
//   rd_en         framebuffer read strobe
//   rd_addr       pixel address y*HOR_ACTIVE_PIXELS+x
//   rd_buf        front buffer select (renderer writes ~rd_buf)
//   rd_data       pixel from RAM, valid one clk after rd_en, held until next read
//   pixel         video pixel, 1=on
//   hsync, vsync  sync pins, SYNC_ACTIVE while asserted
//   swap          one-clk pulse when buffers are exchanged
module framebuffer_scanout #(
  parameter int   HOR_ACTIVE_PIXELS = 640,
  parameter int   HOR_FRONT_PORCH   = 16,
  parameter int   HOR_SYNC_PULSE    = 96,
  parameter int   HOR_BACK_PORCH    = 48,
  parameter int   VER_ACTIVE_PIXELS = 480,
  parameter int   VER_FRONT_PORCH   = 10,
  parameter int   VER_SYNC_PULSE    = 2,
  parameter int   VER_BACK_PORCH    = 33,
  parameter logic SYNC_ACTIVE       = 1'b0,
  localparam int  ADDR_W = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_buf,
  input  logic              rd_data,
  output logic              pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              swap
);

  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);

  localparam int HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
  localparam int HS_END   = HS_START + HOR_SYNC_PULSE;
  localparam int VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
  localparam int VS_END   = VS_START + VER_SYNC_PULSE;

  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(HOR_ACTIVE_PIXELS);

  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  logic [ADDR_W-1:0] line_base;   // v_cnt * HOR_ACTIVE_PIXELS while v_cnt is an active line

  // stage-1 pipeline registers carried alongside rd_en/rd_addr
  logic hs1;
  logic vs1;
  logic act1;

  logic h_last;
  logic v_last;
  logic v_active;
  logic active;
  logic hs_zone;
  logic vs_zone;
  logic swap_point;

  always_comb begin
    h_last     = (int'(h_cnt) == H_TOTAL - 1);
    v_last     = (int'(v_cnt) == V_TOTAL - 1);
    v_active   = (int'(v_cnt) < VER_ACTIVE_PIXELS);
    active     = (int'(h_cnt) < HOR_ACTIVE_PIXELS) && v_active;
    hs_zone    = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    vs_zone    = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    // counters are about to step onto (h=0, v=first blanking line)
    swap_point = h_last && (int'(v_cnt) == VER_ACTIVE_PIXELS - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_buf    <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      act1      <= 1'b0;
      pixel     <= 1'b0;
      hsync     <= ~SYNC_ACTIVE;
      vsync     <= ~SYNC_ACTIVE;
      swap      <= 1'b0;
    end else begin
      // swap is a single-clk pulse regardless of ce
      swap <= 1'b0;

      if (ce) begin
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt     <= '0;
            line_base <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
            // base only needs to track active lines; it parks during blanking
            if (v_active) begin
              line_base <= line_base + LINE_STRIDE;
            end
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end

        // stage 1: issue read and capture sync zones for this counter value
        rd_en <= active;
        if (active) begin
          rd_addr <= line_base + ADDR_W'(h_cnt);
        end
        hs1  <= hs_zone;
        vs1  <= vs_zone;
        act1 <= active;

        // stage 2: rd_data now belongs to the stage-1 read
        pixel <= act1 & rd_data;
        hsync <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;

        if (swap_point && frame_done) begin
          rd_buf <= ~rd_buf;
          swap   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - randomized self-checking bench for framebuffer_scanout
module tb_framebuffer_scanout;

  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HSP = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VSP = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSP + HBP;
  localparam int VT  = VA + VFP + VSP + VBP;
  localparam int FRAME = HT * VT;
  localparam int AW  = $clog2(HA * VA);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_buf;
  logic          rd_data = 1'b0;
  logic          pixel;
  logic          hsync;
  logic          vsync;
  logic          swap;

  int checks = 0;
  int errors = 0;

  bit mem0 [HA*VA];
  bit mem1 [HA*VA];

  // reference state: ce edges since reset, front buffer, last read strobe/address, pulse
  int n;
  bit m_buf;
  bit m_rd_en;
  int m_last_addr;
  bit m_swap;

  framebuffer_scanout #(
    .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HFP), .HOR_SYNC_PULSE(HSP), .HOR_BACK_PORCH(HBP),
    .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VFP), .VER_SYNC_PULSE(VSP), .VER_BACK_PORCH(VBP),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .frame_done(frame_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_buf(rd_buf), .rd_data(rd_data),
    .pixel(pixel), .hsync(hsync), .vsync(vsync), .swap(swap)
  );

  always #5 clk = ~clk;

  // RAM read port: data ready within the clk after the strobe, held between reads
  always @(rd_en or rd_addr or rd_buf) begin
    if (rd_en) rd_data = rd_buf ? mem1[int'(rd_addr)] : mem0[int'(rd_addr)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_buf = 1'b0; m_rd_en = 1'b0; m_last_addr = 0; m_swap = 1'b0;
  endtask

  task automatic verify();
    int p, h, v;
    bit act;
    logic exp_pix, exp_hs, exp_vs;
    exp_pix = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
    if (n >= 2) begin
      // pins show the counter position from two ce steps ago
      p = n - 2;
      h = p % HT;
      v = (p / HT) % VT;
      act = (h < HA) && (v < VA);
      if (act) exp_pix = m_buf ? mem1[v*HA+h] : mem0[v*HA+h];
      exp_hs = (h >= HA + HFP && h < HA + HFP + HSP) ? 1'b0 : 1'b1;
      exp_vs = (v >= VA + VFP && v < VA + VFP + VSP) ? 1'b0 : 1'b1;
    end
    chk("pixel",   32'(pixel),   32'(exp_pix));
    chk("hsync",   32'(hsync),   32'(exp_hs));
    chk("vsync",   32'(vsync),   32'(exp_vs));
    chk("rd_en",   32'(rd_en),   32'(m_rd_en));
    chk("rd_addr", 32'(rd_addr), 32'(m_last_addr));
    chk("rd_buf",  32'(rd_buf),  32'(m_buf));
    chk("swap",    32'(swap),    32'(m_swap));
  endtask

  task automatic tick(input bit ce_v, input bit fd_v);
    int h, v;
    ce = ce_v;
    frame_done = fd_v;
    @(posedge clk);
    m_swap = 1'b0;
    if (ce_v) begin
      h = n % HT;
      v = (n / HT) % VT;
      if (h == HT - 1 && v == VA - 1 && fd_v) begin
        m_swap = 1'b1;
        m_buf = ~m_buf;
      end
      m_rd_en = (h < HA) && (v < VA);
      if (m_rd_en) m_last_addr = v * HA + h;
      n++;
    end
    #1;
    verify();
  endtask

  // reset between clock edges; outputs must change without a clk edge
  task automatic async_reset();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    verify();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit fd;
    for (int i = 0; i < HA*VA; i++) begin
      mem0[i] = bit'($urandom_range(0, 1));
      mem1[i] = bit'($urandom_range(0, 1));
    end
    rst = 1'b1;
    ce = 1'b0;
    frame_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    verify();
    rst = 1'b0;

    // continuous ce, renderer always ready: swap every frame
    repeat (4 * FRAME) tick(1'b1, 1'b1);
    // renderer late: frames repeat, then catches up
    repeat (2 * FRAME) tick(1'b1, 1'b0);
    repeat (FRAME) tick(1'b1, 1'b1);
    // ce every second clk
    for (int i = 0; i < 8 * FRAME; i++) tick(bit'(i % 2), 1'b1);

    // reset part-way through an active line
    repeat (3 * HT + 5) tick(1'b1, 1'b1);
    async_reset();

    // random ce density and random frame_done level
    fd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 37 == 0) fd = bit'($urandom_range(0, 1));
      tick($urandom_range(0, 3) != 0, fd);
    end

    async_reset();
    repeat (3 * FRAME) tick(1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
